// File: rtl/watch_mmss_cnt.sv
// -----------------------------------------------------------------------------
// watch_mmss_cnt
//   BCD minutes:seconds timekeeping counter with a user set mode.
//   Time advances on the 1 Hz enable while in RUN. In SET_MIN and SET_SEC the
//   UP button edits the selected field and timekeeping is halted. The packed
//   BCD word drives a 4-digit FND driver directly.
//
//   Optional build macro WATCH_BLINK_EN: when defined, the field being edited
//   flashes using a phase derived from the 200 Hz enable. When undefined,
//   oBLANK is tied to zero and iEN_200 is unused.
//
// Parameters
//   INIT_MIN   BCD minutes loaded at reset (00..59)
//   INIT_SEC   BCD seconds loaded at reset (00..59)
//   BLINK_DIV  iEN_200 pulses per blink half-period
//
// Ports
//   iCLK       system clock
//   iRESETn    synchronous active-low reset
//   iEN_1      1 Hz one-cycle enable
//   iEN_200    200 Hz one-cycle enable (blink timebase)
//   iBTN_MODE  one-cycle pulse, RUN -> SET_MIN -> SET_SEC -> RUN
//   iBTN_UP    one-cycle pulse, increments the selected field
//   oDATA_CNT  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits per digit
//   oBLANK     per-digit blank flags, bit 3 = min_tens, 1 = digit off
//   oMODE      0 = RUN, 1 = SET_MIN, 2 = SET_SEC
// -----------------------------------------------------------------------------
module watch_mmss_cnt #(
  parameter logic [7:0]  INIT_MIN  = 8'h00,
  parameter logic [7:0]  INIT_SEC  = 8'h00,
  parameter int unsigned BLINK_DIV = 100
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iEN_1,
  input  logic        iEN_200,
  input  logic        iBTN_MODE,
  input  logic        iBTN_UP,
  output logic [15:0] oDATA_CNT,
  output logic [3:0]  oBLANK,
  output logic [1:0]  oMODE
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_MIN = 2'd1;
  localparam logic [1:0] ST_SET_SEC = 2'd2;

  logic [1:0] state_q, state_next;
  logic [7:0] min_q, min_next;
  logic [7:0] sec_q, sec_next;
  logic [8:0] sec_inc;
  logic [8:0] min_inc;

  // Mod-60 BCD increment. Returns {carry, value}. Out-of-range digits are
  // folded back into range so the counter self-recovers from a bad load.
  function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    logic       carry;
    ones  = v[3:0];
    tens  = v[7:4];
    carry = 1'b0;
    if (ones >= 4'd9) begin
      ones = 4'd0;
      if (tens >= 4'd5) begin
        tens  = 4'd0;
        carry = 1'b1;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      ones = ones + 4'd1;
    end
    return {carry, tens, ones};
  endfunction

  assign sec_inc = bcd_inc60(sec_q);
  assign min_inc = bcd_inc60(min_q);

  // A MODE pulse always wins over UP in the same cycle. In RUN a coincident
  // tick is still applied; in the set states ticks are ignored entirely.
  always_comb begin
    state_next = state_q;
    min_next   = min_q;
    sec_next   = sec_q;
    case (state_q)
      ST_RUN: begin
        if (iEN_1) begin
          sec_next = sec_inc[7:0];
          if (sec_inc[8]) begin
            min_next = min_inc[7:0];
          end
        end
        if (iBTN_MODE) begin
          state_next = ST_SET_MIN;
        end
      end
      ST_SET_MIN: begin
        if (iBTN_MODE) begin
          state_next = ST_SET_SEC;
        end else if (iBTN_UP) begin
          min_next = min_inc[7:0];
        end
      end
      ST_SET_SEC: begin
        if (iBTN_MODE) begin
          state_next = ST_RUN;
        end else if (iBTN_UP) begin
          sec_next = sec_inc[7:0];
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state_q <= ST_RUN;
      min_q   <= INIT_MIN;
      sec_q   <= INIT_SEC;
    end else begin
      state_q <= state_next;
      min_q   <= min_next;
      sec_q   <= sec_next;
    end
  end

  assign oDATA_CNT = {min_q, sec_q};
  assign oMODE     = state_q;

`ifdef WATCH_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic             phase_hidden_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             next_is_set;
  logic             entering_set;
  logic             up_accepted;

  assign next_is_set  = (state_next == ST_SET_MIN) || (state_next == ST_SET_SEC);
  assign entering_set = next_is_set && (state_next != state_q);
  assign up_accepted  = iBTN_UP && !iBTN_MODE &&
                        ((state_q == ST_SET_MIN) || (state_q == ST_SET_SEC));

  // Entering a set state or accepting an edit restarts the visible
  // half-period, so the user always sees the value just changed.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      phase_hidden_q <= 1'b0;
      blink_cnt_q    <= '0;
    end else if (!next_is_set || entering_set || up_accepted) begin
      phase_hidden_q <= 1'b0;
      blink_cnt_q    <= '0;
    end else if (iEN_200) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_q    <= '0;
        phase_hidden_q <= ~phase_hidden_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    oBLANK = '0;
    if (phase_hidden_q) begin
      case (state_q)
        ST_SET_MIN: oBLANK = 4'b1100;
        ST_SET_SEC: oBLANK = 4'b0011;
        default:    oBLANK = '0;
      endcase
    end
  end
`else
  logic [31:0] unused_blink;
  assign unused_blink = {31'(BLINK_DIV), iEN_200};
  assign oBLANK       = '0;
`endif

endmodule

// File: tb/tb_watch_mmss_cnt.sv
module tb_watch_mmss_cnt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_1 = 1'b0;
  logic        en_200 = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_up = 1'b0;
  logic [15:0] data_cnt, data_cnt2;
  logic [3:0]  blank, blank2;
  logic [1:0]  mode, mode2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

`ifdef WATCH_BLINK_EN
  localparam logic [3:0] HID_MIN = 4'b1100;
  localparam logic [3:0] HID_SEC = 4'b0011;
`else
  localparam logic [3:0] HID_MIN = 4'b0000;
  localparam logic [3:0] HID_SEC = 4'b0000;
`endif

  always #5 clk = ~clk;

  watch_mmss_cnt dut (
    .iCLK(clk), .iRESETn(rst_n), .iEN_1(en_1), .iEN_200(en_200),
    .iBTN_MODE(btn_mode), .iBTN_UP(btn_up),
    .oDATA_CNT(data_cnt), .oBLANK(blank), .oMODE(mode)
  );

  watch_mmss_cnt #(.INIT_MIN(8'h59), .INIT_SEC(8'h58)) dut2 (
    .iCLK(clk), .iRESETn(rst_n), .iEN_1(en_1), .iEN_200(en_200),
    .iBTN_MODE(btn_mode), .iBTN_UP(btn_up),
    .oDATA_CNT(data_cnt2), .oBLANK(blank2), .oMODE(mode2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the given one-cycle pulses; outputs are sampled 1 ns
  // after the edge, by which time the registered result is visible.
  task automatic step(input logic e1, input logic e200, input logic m, input logic u);
    en_1 = e1; en_200 = e200; btn_mode = m; btn_up = u;
    @(posedge clk);
    #1;
    en_1 = 1'b0; en_200 = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_data", data_cnt, 16'h0000);
    check("rst_mode", 16'(mode), 16'h0000);
    check("rst_blank", 16'(blank), 16'h0000);
    check("rst_data_init", data_cnt2, 16'h5958);

    // Full wrap on the 59:58 instance, 61 ticks on the default one
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_5959", data_cnt2, 16'h5959);
    check("run_0001", data_cnt, 16'h0001);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_0000", data_cnt2, 16'h0000);
    for (int unsigned i = 0; i < 59; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_61_ticks", data_cnt, 16'h0101);
    check("run_61_mode", 16'(mode), 16'h0000);
    check("run_61_blank", 16'(blank), 16'h0000);
    check("wrap_plus59", data_cnt2, 16'h0059);

    // UP ignored in RUN, then SET_MIN edits with ticks ignored
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("run_up_ignored", data_cnt, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("mode_set_min", 16'(mode), 16'h0001);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("set_min_data", data_cnt, 16'h0300);
    check("set_min_hold", 16'(mode), 16'h0001);

    // SET_SEC: 59 -> 00 without carry, MODE beats UP
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("mode_set_sec", 16'(mode), 16'h0002);
    for (int unsigned i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("set_sec_59", data_cnt, 16'h0359);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("set_sec_wrap", data_cnt, 16'h0300);
    for (int unsigned i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("mode_up_mode", 16'(mode), 16'h0000);
    check("mode_up_data", data_cnt, 16'h0359);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_sec_carry", data_cnt, 16'h0400);

    // Tick + MODE in RUN applies the tick; in SET_SEC it is dropped
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("tick_mode_run_d", data_cnt, 16'h0401);
    check("tick_mode_run_m", 16'(mode), 16'h0001);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("tick_mode_sec_d", data_cnt, 16'h0401);
    check("tick_mode_sec_m", 16'(mode), 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_tick", data_cnt, 16'h0402);

    // Minutes 59 -> 00 in SET_MIN leaves seconds alone
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 56; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("set_min_59", data_cnt, 16'h0002);

    // Reset mid-edit with other inputs active
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("edit_1234", data_cnt, 16'h1234);
    check("edit_mode", 16'(mode), 16'h0002);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    check("mid_rst_data", data_cnt, 16'h0000);
    check("mid_rst_mode", 16'(mode), 16'h0000);
    check("mid_rst_blank", 16'(blank), 16'h0000);
    check("mid_rst_init", data_cnt2, 16'h5958);

    // Blink phase in the set states, none in RUN
    for (int unsigned i = 0; i < 150; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("run_no_blink", 16'(blank), 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_vis_99", 16'(blank), 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_hid_min", 16'(blank), 16'(HID_MIN));
    for (int unsigned i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_hid_199", 16'(blank), 16'(HID_MIN));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("blink_up_vis", 16'(blank), 16'h0000);
    check("blink_up_data", data_cnt, 16'h0100);
    for (int unsigned i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_hid_again", 16'(blank), 16'(HID_MIN));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_enter_sec", 16'(blank), 16'h0000);
    for (int unsigned i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("blink_hid_sec", 16'(blank), 16'(HID_SEC));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("blink_run_clear", 16'(blank), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/watch_mmss_cnt.md
Name: watch_mmss_cnt

Overview:
- BCD minutes:seconds timekeeping counter with a user set mode.
- Consumes the 1 Hz and 200 Hz enables from the frequency divider and single-cycle button pulses from the upstream debouncer.
- Produces the 16-bit packed BCD word that feeds the 4-digit FND driver directly. Also produces per-digit blank flags so the driver can flash the field being set.

Parameters:
- INIT_MIN, 8'h00: BCD minute value loaded at reset; must be a legal BCD value 00..59.
- INIT_SEC, 8'h00: BCD second value loaded at reset; must be a legal BCD value 00..59.
- BLINK_DIV, 100: number of iEN_200 pulses per blink half-period (100 gives a 1 Hz toggle).

Ports:
- iCLK  input  1  system clock.
- iRESETn  input  1  synchronous reset, active-low, sampled on the rising edge of iCLK.
- iEN_1  input  1  1 Hz one-cycle enable.
- iEN_200  input  1  200 Hz one-cycle enable (blink timebase).
- iBTN_MODE  input  1  debounced one-cycle pulse; cycles the mode.
- iBTN_UP  input  1  debounced one-cycle pulse; increments the selected field.
- oDATA_CNT  output  16  packed BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits per digit.
- oBLANK  output  4  per-digit blank flags, bit 3 = min_tens, bit 0 = sec_ones; 1 = digit off.
- oMODE  output  2  current state: 0 = RUN, 1 = SET_MIN, 2 = SET_SEC.

Behaviour:
- Reset (iRESETn=0 at a clock edge):
  - oDATA_CNT = {INIT_MIN, INIT_SEC}.
  - state RUN, oMODE = 0, oBLANK = 4'b0000.
  - blink phase = visible, blink counter = 0.
  - Reset overrides every other input in that cycle.
- Latency: all outputs are registered and reflect an event one cycle after the sampled pulse.
- FSM:
  - RUN -> SET_MIN -> SET_SEC -> RUN, one step per iBTN_MODE pulse.
  - oMODE value 3 is unreachable; if entered, the FSM goes to RUN on the next clock.
- RUN:
  - Each iEN_1 increments sec_ones.
  - sec_ones 9 -> 0 carries to sec_tens.
  - Seconds 59 -> 00 carries to minutes.
  - Minutes 59 -> 00 wraps, no further carry.
  - iBTN_UP is ignored.
- SET_MIN:
  - Timekeeping halts; iEN_1 is ignored.
  - iBTN_UP increments minutes in BCD; 59 -> 00, no effect on seconds.
- SET_SEC:
  - Timekeeping halts.
  - iBTN_UP increments seconds in BCD; 59 -> 00, no carry to minutes.
- Simultaneous events:
  - iBTN_MODE with iBTN_UP in the same cycle: the mode change wins; the UP pulse is dropped.
  - iEN_1 with iBTN_MODE while in RUN: the tick is applied and the state changes to SET_MIN in the same cycle.
  - iEN_1 with iBTN_MODE while in SET_SEC: the tick is ignored; the state becomes RUN, and counting resumes on the next iEN_1.
- Arithmetic:
  - Each BCD digit stays within 0..9; tens digits stay within 0..5.
  - No binary intermediate is exposed on oDATA_CNT.
- Reset mid-edit: returns to RUN with the INIT values; no partially edited value survives.

Optional Feature:
- Macro: WATCH_BLINK_EN.
- Defined:
  - In SET_MIN or SET_SEC, a counter of iEN_200 pulses toggles the blink phase every BLINK_DIV pulses.
  - While the phase is "hidden", oBLANK = 4'b1100 in SET_MIN and 4'b0011 in SET_SEC; otherwise oBLANK = 0.
  - On entering a set state, and on every accepted iBTN_UP, the phase is forced to visible and the counter is cleared.
  - In RUN, oBLANK = 0 and the counter is held at 0.
- Undefined: no blink logic is built; oBLANK is tied to 4'b0000; iEN_200 is unused.

Test Plan:
- Reset with defaults, then 61 iEN_1 pulses in RUN -> oDATA_CNT = 16'h0101, oMODE = 0, oBLANK = 0.
- INIT_MIN=8'h59, INIT_SEC=8'h58, 2 iEN_1 pulses -> 16'h5959, then 16'h0000 (full wrap).
- From reset: iBTN_MODE, 3x iBTN_UP, then 10 iEN_1 pulses -> oDATA_CNT = 16'h0300, oMODE = 1 (held while setting).
- In SET_SEC at seconds 59: iBTN_UP -> 16'hMM00 with minutes unchanged; iBTN_MODE and iBTN_UP in the same cycle -> oMODE = 0, value unchanged.
- WATCH_BLINK_EN defined, enter SET_MIN: oBLANK = 0 for 100 iEN_200 pulses, then 4'b1100 for 100 pulses; an iBTN_UP during the hidden phase -> oBLANK = 0 on the next cycle.
- Reset asserted for one cycle while in SET_SEC with value 16'h1234 -> next cycle 16'h0000, oMODE = 0, oBLANK = 0.
